// File: rtl/popcount_pkg.sv
// Shared types for the multi-cycle popcount block.
package popcount_pkg;

   // IDLE waits for a word, COUNT walks the slices, DONE holds the result.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } popcount_state_t;

endpackage : popcount_pkg

// File: rtl/popcount_sequencer_count_ones.sv
// Narrow combinational popcount, shared across all slices of the wide word.
module count_ones #(
   parameter int N = 8
) (
   input  logic [N-1:0]               bits_i,
   output logic [$clog2(N+1)-1:0]     count_o
);

   localparam int CW = $clog2(N + 1);

   // Sum the individual bits of the slice.
   always_comb begin
      count_o = '0;
      for (int i = 0; i < N; i++) begin
         count_o = count_o + CW'(bits_i[i]);
      end
   end

endmodule : count_ones

// File: rtl/popcount_sequencer.sv
// Multi-cycle popcount of a WIDTH-bit word, one CHUNK-bit slice per cycle,
// with valid/ready handshakes on both sides.
module popcount_sequencer
   import popcount_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CHUNK = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(WIDTH+1)-1:0] out_count,
   output logic                       busy
);

   localparam int NUM_CHUNKS = WIDTH / CHUNK;
   localparam int CNT_W      = $clog2(WIDTH + 1);
   localparam int SLICE_W    = $clog2(CHUNK + 1);
   localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   // Reject parameter combinations that would leave a partial slice.
   if (CHUNK < 1) begin : g_chunk_check
      $error("popcount_sequencer: CHUNK must be >= 1");
   end else if ((WIDTH % CHUNK) != 0) begin : g_width_check
      $error("popcount_sequencer: WIDTH must be a multiple of CHUNK");
   end

   popcount_state_t                       state_q, state_d;
   logic [NUM_CHUNKS-1:0][CHUNK-1:0]      word_q;
   logic [IDX_W-1:0]                      idx_q;
   logic [CNT_W-1:0]                      acc_q;
   logic                                  out_valid_q;
   logic [CNT_W-1:0]                      out_count_q;

   logic [CHUNK-1:0]                      slice;
   logic [SLICE_W-1:0]                    slice_count;
   logic [CNT_W-1:0]                      acc_sum;

   count_ones #(
      .N(CHUNK)
   ) u_count_ones (
      .bits_i  (slice),
      .count_o (slice_count)
   );

   assign acc_sum = acc_q + CNT_W'(slice_count);

   // Next-state decode, LSB-first slice select and the handshake status flags.
   always_comb begin
      state_d  = state_q;
      slice    = word_q[idx_q];
      in_ready = (state_q == IDLE);
      busy     = (state_q != IDLE);
      case (state_q)
         IDLE:    if (in_valid)          state_d = COUNT;
         COUNT:   if (idx_q == LAST_IDX) state_d = DONE;
         DONE:    if (out_ready)         state_d = IDLE;
         default:                        state_d = IDLE;
      endcase
   end

   // Captures the word, accumulates one slice per cycle and holds the result until taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         word_q      <= '0;
         idx_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_count_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  word_q <= in_data;
                  acc_q  <= '0;
                  idx_q  <= '0;
               end
            end
            COUNT: begin
               acc_q <= acc_sum;
               if (idx_q == LAST_IDX) begin
                  idx_q       <= '0;
                  out_count_q <= acc_sum;
                  out_valid_q <= 1'b1;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_count = out_count_q;

endmodule : popcount_sequencer

// File: tb/tb_popcount_sequencer.sv
// Scoreboard bench for popcount_sequencer: driver pushes expected counts,
// a negedge monitor pops and compares whenever a result is handed over.
module tb_popcount_sequencer;

   localparam int WIDTH      = 64;
   localparam int CHUNK      = 8;
   localparam int NUM_CHUNKS = WIDTH / CHUNK;
   localparam int CNT_W      = $clog2(WIDTH + 1);

   typedef struct {
      int unsigned count;
      int          acceptEdge;
   } expect_t;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] out_count;
   logic             busy;

   logic             in8_valid;
   logic             in8_ready;
   logic [7:0]       in8_data;
   logic             out8_valid;
   logic             out8_ready;
   logic [3:0]       out8_count;
   logic             busy8;

   int      checks;
   int      errors;
   int      cycleCnt;
   expect_t sb[$];
   bit      prevValid;
   bit      expectLow;
   int      lastCount;
   bit      randBp;

   popcount_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count),
      .busy      (busy)
   );

   popcount_sequencer #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in8_valid),
      .in_ready  (in8_ready),
      .in_data   (in8_data),
      .out_valid (out8_valid),
      .out_ready (out8_ready),
      .out_count (out8_count),
      .busy      (busy8)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter used to measure latency and accept spacing.
   always @(posedge clk) cycleCnt++;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cycleCnt);
      end
   endtask

   // Offers a word until accepted, then records the reference count in the scoreboard.
   task automatic applyStimulus(input logic [WIDTH-1:0] word, input bit hold, output int acceptEdge);
      bit accepted;
      accepted   = 1'b0;
      acceptEdge = -1;
      in_data    = word;
      in_valid   = 1'b1;
      for (int i = 0; i < 100 && !accepted; i++) begin
         @(negedge clk);
         if (in_ready) begin
            accepted   = 1'b1;
            acceptEdge = cycleCnt + 1;
            sb.push_back('{count: $countones(word), acceptEdge: acceptEdge});
         end
      end
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout actual=no_accept expected=accept");
      end
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
      in_data = {$urandom, $urandom};
   endtask

   // Waits until every expected result has been handed over, optionally throttling out_ready.
   task automatic waitDrain();
      for (int i = 0; i < 300 && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
         if (randBp) out_ready = 1'($urandom_range(0, 1));
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout actual=%0d pending expected=0", sb.size());
         sb.delete();
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares each presented result against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         prevValid = 1'b0;
         expectLow = 1'b0;
      end else begin
         if (expectLow) begin
            checkOutput("pulse_end_valid", out_valid, 0);
            checkOutput("count_kept", out_count, lastCount);
            expectLow = 1'b0;
         end
         if (out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_output actual=%0d expected=none", out_count);
            end else begin
               if (!prevValid) checkOutput("latency", cycleCnt - sb[0].acceptEdge, NUM_CHUNKS);
               if (out_ready) begin
                  checkOutput("count", out_count, sb[0].count);
                  lastCount = sb[0].count;
                  void'(sb.pop_front());
                  expectLow = 1'b1;
               end else begin
                  checkOutput("hold_count", out_count, sb[0].count);
                  checkOutput("hold_in_ready", in_ready, 0);
               end
            end
         end
         prevValid = out_valid;
      end
   end

   // Main stimulus sequence.
   initial begin
      int e1;
      int e2;
      int waitCnt;
      logic [WIDTH-1:0] w;
      logic [7:0] b;

      checks    = 0;
      errors    = 0;
      cycleCnt  = 0;
      randBp    = 1'b0;
      lastCount = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      in8_valid = 1'b0;
      in8_data  = '0;
      out8_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_count", out_count, 0);
      checkOutput("rst_busy", busy, 0);

      $display("[TB] zero word");
      applyStimulus(64'h0, 1'b0, e1);
      checkOutput("count_busy", busy, 1);
      checkOutput("count_in_ready", in_ready, 0);
      waitDrain();

      $display("[TB] all ones and mixed pattern");
      applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, e1);
      waitDrain();
      applyStimulus(64'h0123_4567_89AB_CDEF, 1'b0, e1);
      waitDrain();

      $display("[TB] backpressure");
      out_ready = 1'b0;
      applyStimulus(64'h0123_4567_89AB_CDEF, 1'b0, e1);
      waitCnt = 0;
      while (!out_valid && waitCnt < 50) begin
         @(posedge clk);
         #1;
         waitCnt++;
      end
      checkOutput("bp_valid_seen", out_valid, 1);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("bp_busy", busy, 1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_release_in_ready", in_ready, 1);
      checkOutput("bp_release_busy", busy, 0);
      checkOutput("bp_release_valid", out_valid, 0);
      waitDrain();

      $display("[TB] back-to-back");
      applyStimulus(64'h1, 1'b1, e1);
      applyStimulus(64'h8000_0000_0000_0003, 1'b0, e2);
      checkOutput("b2b_gap", e2 - e1, NUM_CHUNKS + 2);
      waitDrain();

      $display("[TB] reset mid-count");
      applyStimulus(64'hDEAD_BEEF_CAFE_F00D, 1'b0, e1);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      checkOutput("mid_rst_in_ready", in_ready, 1);
      checkOutput("mid_rst_busy", busy, 0);
      checkOutput("mid_rst_valid", out_valid, 0);
      repeat (12) @(posedge clk);
      #1;
      checkOutput("mid_rst_idle_valid", out_valid, 0);
      applyStimulus(64'hFF, 1'b0, e1);
      waitDrain();

      $display("[TB] randomized words with random backpressure");
      randBp = 1'b1;
      for (int n = 0; n < 24; n++) begin
         w = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0: w = w & {$urandom, $urandom};
            1: w = w | {$urandom, $urandom};
            default: ;
         endcase
         applyStimulus(w, 1'b0, e1);
         waitDrain();
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      randBp = 1'b0;

      $display("[TB] single-chunk configuration");
      for (int n = 0; n < 4; n++) begin
         if (n == 0) b = 8'hA5;
         else        b = 8'($urandom);
         in8_data  = b;
         in8_valid = 1'b1;
         checkOutput("w8_in_ready", in8_ready, 1);
         @(posedge clk);
         #1;
         in8_valid = 1'b0;
         in8_data  = 8'($urandom);
         checkOutput("w8_valid_early", out8_valid, 0);
         @(posedge clk);
         #1;
         checkOutput("w8_valid", out8_valid, 1);
         checkOutput("w8_count", out8_count, $countones(b));
         @(posedge clk);
         #1;
         checkOutput("w8_valid_end", out8_valid, 0);
      end

      $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule : tb_popcount_sequencer
